sram_req_arbiter: RTL and testbench
===================================

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 SHALL have parameter OUTST_DEPTH, default 4, max in-flight accepted requests awaiting data_ok (power of two, 2..8).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports inst_req/data_req  in  1  requester wants a transfer; held high until its addr_ok.
REQ-005 SHALL have ports inst_wr/data_wr  in  1  1 = write, 0 = read.
REQ-006 SHALL have ports inst_size/data_size  in  2  0:1 B, 1:2 B, 2:4 B.
REQ-007 SHALL have ports inst_wstrb/data_wstrb  in  4  byte write strobes.
REQ-008 SHALL have ports inst_addr/data_addr  in  32  physical request address.
REQ-009 SHALL have ports inst_wdata/data_wdata  in  32  write data.
REQ-010 SHALL have ports inst_addr_ok/data_addr_ok  out  1  request accepted this cycle.
REQ-011 SHALL have ports inst_data_ok/data_data_ok  out  1  response for that requester this cycle.
REQ-012 SHALL have ports inst_rdata/data_rdata  out  32  read data, both driven from mem_rdata.
REQ-013 SHALL have ports mem_req, mem_wr  out  1 each  shared-port request and direction.
REQ-014 SHALL have ports mem_size  out  2 and mem_wstrb  out  4; mem_addr, mem_wdata  out  32 each  muxed from the granted requester.
REQ-015 SHALL have ports mem_addr_ok, mem_data_ok  in  1 each  and mem_rdata  in  32  shared-port handshake and read data.

Function
REQ-016 SHALL keep a grant state machine: IDLE, LOCK_I, LOCK_D.
REQ-017 In IDLE, if the pending counter is below OUTST_DEPTH and any req is high, SHALL pick a winner combinationally, drive its fields on mem_* and assert mem_req in the same cycle (zero-cycle latency).
REQ-018 If a request is issued without mem_addr_ok, SHALL move to LOCK_I or LOCK_D and keep that requester's fields on mem_* until mem_addr_ok, regardless of the other req.
REQ-019 On mem_addr_ok, SHALL pulse only the granted requester's addr_ok, push its ID (0 = inst, 1 = data) into the in-order ID FIFO, and return to IDLE.
REQ-020 Back-to-back accepts in consecutive cycles SHALL be supported.
REQ-021 SHALL hold mem_req low while the counter equals OUTST_DEPTH; a pop in the same cycle does not free a slot until the next cycle.
REQ-022 On mem_data_ok with a non-empty FIFO, SHALL pop the head and pulse inst_data_ok (head = 0) or data_data_ok (head = 1) in the same cycle.
REQ-023 mem_data_ok with an empty FIFO SHALL be ignored: no data_ok pulse and no counter change.
REQ-024 A simultaneous push and pop SHALL leave the counter unchanged and keep the FIFO order correct.
REQ-025 FIFO read and write pointers SHALL wrap modulo OUTST_DEPTH.
REQ-026 When mem_req is low, mem_* data fields SHALL be driven to zero.

Reset
REQ-027 Asserting resetn low at any time, including mid-handshake, SHALL immediately force state IDLE, counter 0, pointers 0 and round-robin pointer "inst last", and drive every output to 0.
REQ-028 After resetn deasserts, in-flight responses from before reset SHALL be ignored (REQ-023 behaviour).

Configuration
REQ-029 With MEM_ARB_RR_EN defined, arbitration in IDLE SHALL be round-robin: the requester not granted most recently wins a tie, and the pointer updates on each accepted request.
REQ-030 Without MEM_ARB_RR_EN, data SHALL always win a tie over inst (fixed priority), and no round-robin register SHALL exist.

Verification
REQ-031 inst_req=data_req=1 in IDLE, mem_addr_ok=1 -> without RR: data granted at cycle 0, inst at cycle 1; with RR, after reset: data at cycle 0, inst at cycle 1, data at cycle 2.
REQ-032 data_req issued, mem_addr_ok low for 3 cycles, inst_req rises at cycle 1 -> mem_addr stays data_addr until addr_ok, then inst is granted.
REQ-033 Accept 4 requests, no data_ok (OUTST_DEPTH=4) -> mem_req stays 0 with req high; one mem_data_ok -> mem_req high the next cycle.
REQ-034 Issue order I, D, I; three mem_data_ok with rdata 0x11, 0x22, 0x33 -> inst_data_ok/0x11, data_data_ok/0x22, inst_data_ok/0x33.
REQ-035 resetn pulsed low while in LOCK_D with 2 pending, then mem_data_ok -> all outputs 0 during reset; the later data_ok produces no pulse.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: arbitrates inst/data SRAM-like requesters onto one shared port, tracking responses in order.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data always wins a tie over inst.
module sram_req_arbiter #(
    parameter int OUTST_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam int AW = $clog2(OUTST_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [OUTST_DEPTH-1:0] id_q;
    logic                   prio_d;
    logic                   sel_d;
    logic                   issue;
    logic                   accept;
    logic                   pop;

`ifdef MEM_ARB_RR_EN
    logic last_d;
    assign prio_d = ~last_d;
`else
    assign prio_d = 1'b1;
`endif

    // Grant selection, shared-port muxing and requester handshakes; everything is held at zero during reset.
    always_comb begin
        sel_d        = (state == LOCK_D) | ((state == IDLE) & data_req & (~inst_req | prio_d));
        issue        = resetn & ((state != IDLE) | ((cnt < CW'(OUTST_DEPTH)) & (inst_req | data_req)));
        accept       = issue & mem_addr_ok;
        pop          = resetn & mem_data_ok & (cnt != '0);
        mem_req      = issue;
        mem_wr       = issue & (sel_d ? data_wr : inst_wr);
        mem_size     = issue ? (sel_d ? data_size : inst_size) : '0;
        mem_wstrb    = issue ? (sel_d ? data_wstrb : inst_wstrb) : '0;
        mem_addr     = issue ? (sel_d ? data_addr : inst_addr) : '0;
        mem_wdata    = issue ? (sel_d ? data_wdata : inst_wdata) : '0;
        inst_addr_ok = accept & ~sel_d;
        data_addr_ok = accept & sel_d;
        inst_data_ok = pop & ~id_q[rd_ptr];
        data_data_ok = pop & id_q[rd_ptr];
        inst_rdata   = resetn ? mem_rdata : '0;
        data_rdata   = resetn ? mem_rdata : '0;
    end

    // Grant lock, outstanding count and FIFO pointers; a blocked request locks its requester until accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state  <= accept ? IDLE : issue ? (sel_d ? LOCK_D : LOCK_I) : IDLE;
            cnt    <= cnt + CW'(accept) - CW'(pop);
            wr_ptr <= wr_ptr + AW'(accept);
            rd_ptr <= rd_ptr + AW'(pop);
        end
    end

    // In-order record of which requester owns each outstanding response.
    always_ff @(posedge clk) begin
        if (accept)
            id_q[wr_ptr] <= sel_d;
    end

`ifdef MEM_ARB_RR_EN
    // Remember the most recently accepted requester so the other one wins the next tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            last_d <= 1'b0;
        else if (accept)
            last_d <= sel_d;
    end
`endif
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: directed vector bench for sram_req_arbiter.
module tb_sram_req_arbiter;
`ifdef MEM_ARB_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif
    localparam logic [31:0] IA = 32'h1000_0040;
    localparam logic [31:0] IW = 32'h1234_5678;
    localparam logic [31:0] DA = 32'h2000_0080;
    localparam logic [31:0] DW = 32'hcafe_f00d;

    typedef struct {
        logic        ir;
        logic        dr;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        logic [1:0]  g;
        logic [3:0]  hs;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0, data_req = 1'b0;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;
    int          total = 0;
    int          bad = 0;
    vec_t        tbl[$];
    vec_t        post[$];

    always #5 clk = ~clk;

    sram_req_arbiter #(.OUTST_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(1'b0), .inst_size(2'd2), .inst_wstrb(4'hf),
        .inst_addr(IA), .inst_wdata(IW),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(1'b1), .data_size(2'd0), .data_wstrb(4'h1),
        .data_addr(DA), .data_wdata(DW),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    function automatic vec_t mk(logic ir, logic dr, logic aok, logic dok, logic [31:0] rd, logic [1:0] g, logic [3:0] hs);
        vec_t v;
        v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.rd = rd; v.g = g; v.hs = hs;
        return v;
    endfunction

    function automatic logic [71:0] exp_bus(logic [1:0] g);
        return g == 2'd1 ? {1'b1, 1'b0, 2'd2, 4'hf, IA, IW} :
               g == 2'd2 ? {1'b1, 1'b1, 2'd0, 4'h1, DA, DW} : 72'h0;
    endfunction

    task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t v, string tag);
        @(negedge clk);
        inst_req = v.ir; data_req = v.dr; mem_addr_ok = v.aok; mem_data_ok = v.dok; mem_rdata = v.rd;
        #1;
        chk({tag, " bus"}, {mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, exp_bus(v.g));
        chk({tag, " hs"}, 72'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 72'(v.hs));
        chk({tag, " rdata"}, 72'({inst_rdata, data_rdata}), 72'({v.rd, v.rd}));
    endtask

    task automatic reset_chk(string tag);
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h99;
        #1;
        chk({tag, " bus"}, {mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, 72'h0);
        chk({tag, " hs"}, 72'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 72'h0);
        chk({tag, " rdata"}, 72'({inst_rdata, data_rdata}), 72'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back(mk(1, 1,  1, 0, 32'h0,  2'd2, 4'b0100));
        tbl.push_back(mk(1, RR, 1, 0, 32'h0,  2'd1, 4'b1000));
        tbl.push_back(mk(1, 1,  1, 0, 32'h0,  2'd2, 4'b0100));
        tbl.push_back(mk(0, 0,  0, 1, 32'h11, 2'd0, 4'b0001));
        tbl.push_back(mk(0, 1,  0, 0, 32'h0,  2'd2, 4'b0000));
        tbl.push_back(mk(1, 1,  0, 0, 32'h0,  2'd2, 4'b0000));
        tbl.push_back(mk(1, 1,  0, 0, 32'h0,  2'd2, 4'b0000));
        tbl.push_back(mk(1, 1,  1, 0, 32'h0,  2'd2, 4'b0100));
        tbl.push_back(mk(1, 0,  1, 0, 32'h0,  2'd1, 4'b1000));
        tbl.push_back(mk(1, 1,  1, 0, 32'h0,  2'd0, 4'b0000));
        tbl.push_back(mk(1, 0,  1, 1, 32'h22, 2'd0, 4'b0010));
        tbl.push_back(mk(1, 0,  1, 0, 32'h0,  2'd1, 4'b1000));
        tbl.push_back(mk(0, 0,  0, 1, 32'h33, 2'd0, 4'b0001));
        tbl.push_back(mk(0, 0,  0, 1, 32'h44, 2'd0, 4'b0001));
        tbl.push_back(mk(0, 1,  1, 1, 32'h55, 2'd2, 4'b0110));
        tbl.push_back(mk(0, 0,  0, 1, 32'h66, 2'd0, 4'b0010));
        tbl.push_back(mk(0, 0,  0, 1, 32'h77, 2'd0, 4'b0001));
        tbl.push_back(mk(0, 0,  0, 1, 32'h88, 2'd0, 4'b0000));
        tbl.push_back(mk(1, 0,  0, 0, 32'h0,  2'd1, 4'b0000));
        tbl.push_back(mk(1, 1,  0, 0, 32'h0,  2'd1, 4'b0000));
        tbl.push_back(mk(1, 1,  1, 0, 32'h0,  2'd1, 4'b1000));
        tbl.push_back(mk(0, 1,  1, 0, 32'h0,  2'd2, 4'b0100));
        tbl.push_back(mk(0, 1,  0, 0, 32'h0,  2'd2, 4'b0000));
        post.push_back(mk(0, 0, 0, 1, 32'haa, 2'd0, 4'b0000));
        post.push_back(mk(1, 1, 1, 0, 32'h0,  2'd2, 4'b0100));
        post.push_back(mk(0, 0, 0, 1, 32'hbb, 2'd0, 4'b0001));
        post.push_back(mk(0, 0, 0, 1, 32'hcc, 2'd0, 4'b0000));

        reset_chk("por");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("v%0d", i));

        @(negedge clk);
        resetn = 1'b0;
        reset_chk("mid_reset");
        @(negedge clk);
        resetn = 1'b1;
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        for (int i = 0; i < post.size(); i++)
            apply(post[i], $sformatf("post%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
